receiver: RTL
=============

# receiver

Serial-to-parallel UART receive block: recovers 8N1 frames (1 start, 8 data LSB-first, 1 stop) from the asynchronous `rxd` line, checks framing, and presents each byte with a one-cycle valid strobe. It is the receive-side counterpart of the team's UART transmitter. Both sides share the same `clk_freq`/`baud_rate` parameterisation, so they interoperate at identical settings. It sits between the board RX pin and the byte consumer (FIFO or command parser).

## Interface
- `clk_freq`, default 100000000: clock frequency in Hz.
- `baud_rate`, default 9600: line rate in bit/s.
- Derived `div_val` = clk_freq / baud_rate, integer truncating. For defaults, 10416.
- Derived `half_val` = div_val / 2, truncating. For defaults, 5208.
- Legal range: 4 ≤ div_val ≤ 65535.

- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `rxd`  in  1  asynchronous serial input; idle high.
- `data`  out  8  last correctly framed byte; holds until the next good frame.
- `valid`  out  1  one-cycle pulse when `data` updates.
- `frame_err`  out  1  one-cycle pulse when the stop bit is sampled low.
- `busy`  out  1  high while a frame is in progress, or while waiting for the line to return idle.

## Operation
- **Input synchronizer:** `rxd` passes through a 2-flop synchronizer, producing `rxd_s`. Both flops reset to 1. All decisions use `rxd_s` only.
- **Counters:** `baud_cnt` is 16 bits; `bit_cnt` is 3 bits (0..7). Data is assembled in `shift_reg[7:0]`, shifted right with the new bit inserted at bit 7.
- **State IDLE:** `busy`=0. If `rxd_s`==0, go to START with `baud_cnt`←0.
- **State START:** increment `baud_cnt`. When `baud_cnt`==half_val-1, sample `rxd_s`.
  - If 0: valid start bit. Go to DATA with `baud_cnt`←0, `bit_cnt`←0.
  - If 1: glitch. Return to IDLE with no output activity.
- **State DATA:** increment `baud_cnt`. When `baud_cnt`==div_val-1:
  - Sample: `shift_reg`←{`rxd_s`, `shift_reg[7:1]`}, `baud_cnt`←0.
  - If `bit_cnt`==7, go to STOP; otherwise `bit_cnt`++.
- **State STOP:** increment `baud_cnt`. When `baud_cnt`==div_val-1, sample `rxd_s`.
  - If 1: `data`←`shift_reg`, `valid`←1, go to IDLE.
  - If 0: `frame_err`←1, `data` unchanged, go to WAIT_IDLE.
- **State WAIT_IDLE:** handles break or stuck-low lines. Remain here until `rxd_s`==1, then go to IDLE.
- **Busy:** `busy`=1 in START, DATA, STOP and WAIT_IDLE; `busy`=0 in IDLE. `busy` is registered, updating with the state.
- **Back-to-back frames:** returning to IDLE at the stop-bit midpoint lets a start edge arriving immediately after the stop bit be accepted without loss.
- **No flow control:** a new good frame overwrites `data` unconditionally. The consumer must capture `data` on `valid`.
- **Reset:** applies in any state, including mid-frame. The partial frame is discarded; no `valid` or `frame_err` is produced for it.

## Timing
- **Reset values:** `data`=8'h00, `valid`=0, `frame_err`=0, `busy`=0, state=IDLE, counters=0, synchronizer flops=1.
- **Edge detection:** a falling edge on `rxd` at cycle e is seen in IDLE at cycle t0 = e+2.
  - START is entered at t0+1.
  - `busy` rises at t0+1.
- **Sample points:**
  - Start sample: cycle t0+half_val.
  - Data bit k (k=0..7): cycle t0+half_val+(k+1)·div_val.
  - Stop sample: t0+half_val+9·div_val.
- **Strobes:** `valid` or `frame_err` is high exactly in the cycle after the stop sample, for one cycle only.
  - `data` is stable from that cycle onward.
  - `busy` falls in that same cycle on a good frame.
- **Mutual exclusion:** `valid` and `frame_err` are never high together.
- **Glitch rejection:** a low pulse shorter than about half_val cycles is rejected. `busy` is high for half_val cycles, then returns to 0.

## Test plan
Unless stated otherwise, use clk_freq=16, baud_rate=1, giving div_val=16 and half_val=8, with 16 clocks per bit.

- **Single frame:** drive frame 0xA5 after reset. Required: `valid` high exactly 1 cycle, `data`=8'hA5, `frame_err` stays 0, `busy` high from e+3 until the `valid` cycle.
- **Back-to-back:** send 0x00 then 0xFF with no idle gap between frames. Required: two `valid` pulses 160 cycles apart, with `data`=8'h00 then 8'hFF.
- **Glitch:** hold `rxd` low for 3 cycles, then return it high. Required: no `valid`, no `frame_err`, `busy` high for 8 cycles then 0, `data` unchanged.
- **Framing error:**
  - Send 0x3C with the stop bit driven low, and hold `rxd` low 40 more cycles. Required: `frame_err` 1-cycle pulse, `valid` 0, `data` retains its prior value, `busy` stays 1 until 3 cycles after `rxd` rises.
  - Then send 0x5A. Required: `data`=8'h5A with `valid`.
- **Reset mid-frame:** assert `reset` for 1 cycle during data bit 4 of 0xC3, then release with `rxd` high. Required: all outputs at their reset values the following cycle, and no `valid` or `frame_err` for the aborted frame.
- **Default parameters:** at 100 MHz / 9600 baud, send 0x96. Required: `data`=8'h96, with `valid` at t0+5208+9·10416+1.

Source files
------------

// File: rtl/receiver.sv
// UART 8N1 receiver: 2-flop synchronizer, mid-bit sampling, framing check.
// Latency: strobe one cycle after the stop-bit sample (t0+half+9*div+1).
// No backpressure: each good frame overwrites data; consumer captures on valid.
module receiver #(
  parameter int clk_freq  = 100000000,
  parameter int baud_rate = 9600
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_rxd,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_frame_err,
  output logic       o_busy
);

  localparam int DIV_VAL  = clk_freq / baud_rate;
  localparam int HALF_VAL = DIV_VAL / 2;
  localparam logic [15:0] DIV_M1  = 16'(DIV_VAL - 1);
  localparam logic [15:0] HALF_M1 = 16'(HALF_VAL - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_IDLE
  } state_t;

  logic [1:0]  r_sync;
  state_t      r_state;
  logic [15:0] r_baud_cnt;
  logic [2:0]  r_bit_cnt;
  logic [7:0]  r_shift;
  logic [7:0]  r_data;
  logic        r_valid;
  logic        r_frame_err;
  logic        r_busy;

  logic        w_rxd_s;
  state_t      w_state_nxt;
  logic [15:0] w_baud_nxt;
  logic [2:0]  w_bit_nxt;
  logic [7:0]  w_shift_nxt;
  logic [7:0]  w_data_nxt;
  logic        w_valid_nxt;
  logic        w_ferr_nxt;

  assign w_rxd_s = r_sync[1];

  // Next-state and next-output decode; strobes default low, everything else holds.
  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud_cnt;
    w_bit_nxt   = r_bit_cnt;
    w_shift_nxt = r_shift;
    w_data_nxt  = r_data;
    w_valid_nxt = 1'b0;
    w_ferr_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_rxd_s) begin
          w_state_nxt = S_START;
          w_baud_nxt  = '0;
        end
      end
      S_START: begin
        if (r_baud_cnt == HALF_M1) begin
          // Still low at mid start bit: genuine start, otherwise a glitch.
          if (!w_rxd_s) begin
            w_state_nxt = S_DATA;
            w_baud_nxt  = '0;
            w_bit_nxt   = '0;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_baud_nxt = r_baud_cnt + 16'd1;
        end
      end
      S_DATA: begin
        if (r_baud_cnt == DIV_M1) begin
          w_shift_nxt = {w_rxd_s, r_shift[7:1]};
          w_baud_nxt  = '0;
          if (r_bit_cnt == 3'd7) begin
            w_state_nxt = S_STOP;
          end else begin
            w_bit_nxt = r_bit_cnt + 3'd1;
          end
        end else begin
          w_baud_nxt = r_baud_cnt + 16'd1;
        end
      end
      S_STOP: begin
        if (r_baud_cnt == DIV_M1) begin
          w_baud_nxt = '0;
          // Leaving at the stop midpoint lets a back-to-back start edge be caught.
          if (w_rxd_s) begin
            w_data_nxt  = r_shift;
            w_valid_nxt = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_ferr_nxt  = 1'b1;
            w_state_nxt = S_WAIT_IDLE;
          end
        end else begin
          w_baud_nxt = r_baud_cnt + 16'd1;
        end
      end
      S_WAIT_IDLE: begin
        // Break or stuck-low line: do not re-arm until the line is high again.
        if (w_rxd_s) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, counters, synchronizer and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sync      <= 2'b11;
      r_state     <= S_IDLE;
      r_baud_cnt  <= '0;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_sync      <= {r_sync[0], i_rxd};
      r_state     <= w_state_nxt;
      r_baud_cnt  <= w_baud_nxt;
      r_bit_cnt   <= w_bit_nxt;
      r_shift     <= w_shift_nxt;
      r_data      <= w_data_nxt;
      r_valid     <= w_valid_nxt;
      r_frame_err <= w_ferr_nxt;
      r_busy      <= (w_state_nxt != S_IDLE);
    end
  end

  assign o_data      = r_data;
  assign o_valid     = r_valid;
  assign o_frame_err = r_frame_err;
  assign o_busy      = r_busy;

endmodule
